booth_mul_seq: RTL
==================

Name: booth_mul_seq

Overview:
- Sequential signed radix-2 Booth multiplier. It is the multiply counterpart to the team's combinational restoring divider, and together they form the integer mul/div pair.
- Processes one multiplier bit per clock and uses a start/ready/done handshake.
- Sits beside the divider in the arithmetic datapath and feeds a 2*WIDTH-bit two's-complement product downstream.

Parameters:
- WIDTH, 8, operand width in bits (two's complement); must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- multiplicand  input  WIDTH  signed operand M; captured on the accepting edge.
- multiplier  input  WIDTH  signed operand Q; captured on the accepting edge.
- ready  output  1  high when idle and able to accept start.
- busy  output  1  high while iterating; equals ~ready.
- product  output  2*WIDTH  signed result; holds its value until the next completion.
- done  output  1  single-cycle pulse marking a new product.

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, ready=1, busy=0, done=0, product=0, accumulator A=0, Q register=0, Q_-1=0, step counter=0.
- States:
  - IDLE: ready=1.
  - RUN: busy=1.
- IDLE -> RUN: start=1 at edge E0. On that edge:
  - M is captured sign-extended to WIDTH+1 bits.
  - Q is captured.
  - A is cleared to WIDTH+1 zero bits.
  - Q_-1 is cleared to 0.
  - count is cleared to 0.
- RUN: one Booth step per edge, based on {Q[0],Q_-1}:
  - 01: A=A+M.
  - 10: A=A-M.
  - 00/11: A unchanged.
  - Then {A,Q,Q_-1} is arithmetic-shifted right by 1, replicating the MSB of A.
  - count increments.
- RUN -> IDLE: on the edge that performs step WIDTH, i.e. edge E0+WIDTH. On that edge:
  - product takes the low 2*WIDTH bits of the post-shift {A,Q}.
  - done goes to 1.
  - ready goes to 1.
- Latency: done is high in the cycle after edge E0+WIDTH, which is WIDTH clocks after acceptance. Throughput is one product per WIDTH+1 cycles.
- done is high for exactly one cycle, then returns to 0.
- Back-to-back: start is sampled high during the done cycle and accepted at E0+WIDTH+1, because the FSM is already IDLE.
- Width rule: A is WIDTH+1 bits, so -M does not overflow when M=-2^(WIDTH-1). The full signed range is exact, including (-2^(WIDTH-1))^2.
- Start while busy: ignored. Captured operands, count and the in-flight result are unaffected, and no request is queued.
- Operand inputs may change freely after the accepting edge. Only the captured copies are used.
- product changes only on a completion edge or on reset.
- rst_n asserted mid-RUN: the operation is abandoned, all registers return to their reset values, and no done pulse is issued, including after rst_n deasserts.
- Zero operand: no special case. The full WIDTH steps still run, giving a fixed latency.

Decomposition:
- Shared package booth_pkg holds:
  - the state enum (IDLE, RUN),
  - the default WIDTH,
  - the count-width function clog2(WIDTH+1).
- The divider and multiplier share the package for the arithmetic datapath.
- One combinational sub-module, booth_step:
  - inputs: A, Q, Q_-1, M.
  - outputs: next A, Q, Q_-1.
  - performs add/sub/none plus the arithmetic shift.
- The top level owns the FSM, counter, operand registers and handshake.

Test Plan:
- 7 x 3 (0x07, 0x03), start 1 cycle -> product=0x0015, done pulses 8 cycles after the accepting edge, ready low for exactly 8 cycles.
- -5 x 6 (0xFB, 0x06) -> product=0xFFE2; then 6 x -5 -> 0xFFE2.
- Corner magnitudes:
  - -128 x -128 (0x80, 0x80) -> 0x4000.
  - -128 x 127 (0x80, 0x7F) -> 0xC080.
  - 0 x -1 -> 0x0000.
- Busy/back-to-back:
  - Start 0x02 x 0x02 pulsed 3 cycles into a 0x0A x 0x0B run -> ignored; product=0x006E with exactly one done.
  - Start 0x03 x 0x04 held during the done cycle -> accepted; second done gives 0x000C after 8 more cycles.
- Reset mid-run: rst_n=0 for 1 cycle at step 4 of 0x10 x 0x10 -> product=0, ready=1, done stays 0 for 20 cycles. The next 0x10 x 0x10 run -> 0x0100.
- Randomised sweep of 1000 operand pairs against a signed reference model -> exact match, one done per accepted start.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared arithmetic datapath types and sizing helpers
package booth_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Step counter must reach WIDTH, hence clog2(WIDTH+1).
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/booth_mul_seq_step.sv
// rtl/booth_mul_seq_step.sv - one radix-2 Booth step: add/sub/none then arithmetic shift right
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    // {sum, q, q_m1} >>> 1, replicating the sign bit of the accumulator
    a_next    = {sum[WIDTH], sum[WIDTH:1]};
    q_next    = {sum[0], q[WIDTH-1:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential signed radix-2 Booth multiplier, one bit per clock
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic             accept, finish;
  logic [WIDTH:0]   a, m;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   a_nx;
  logic [WIDTH-1:0] q_nx;
  logic             q_m1_nx;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a         (a),
    .q         (q),
    .q_m1      (q_m1),
    .m         (m),
    .a_next    (a_nx),
    .q_next    (q_nx),
    .q_m1_next (q_m1_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept   = 1'b1;
        state_nx = RUN;
      end
      RUN: if (count == CW'(WIDTH - 1)) begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        m     <= {multiplicand[WIDTH-1], multiplicand};
        q     <= multiplier;
        a     <= '0;
        q_m1  <= 1'b0;
        count <= '0;
      end else if (state == RUN) begin
        a     <= a_nx;
        q     <= q_nx;
        q_m1  <= q_m1_nx;
        count <= count + 1'b1;
      end
      // Final step's shifted result goes straight to the output register.
      if (finish) product <= {a_nx[WIDTH-1:0], q_nx};
    end
  end

  assign ready = (state == IDLE);
  assign busy  = ~ready;

endmodule
